// File: rtl/imm_gen_pkg.sv
// Shared types and helpers for the pipelined immediate generator: format enum,
// RV base opcodes, the immediate extraction function and the opcode-driven format decoder.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_CSR   = 3'b110,
    FMT_RSV   = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Always built at 64 bits; callers keep the low XLEN bits, which are identical
  // for both widths except for the SHAMT field width.
  function automatic logic [63:0] ext_imm(input logic [31:0] instr, input imm_fmt_e fmt,
                                          input int unsigned xlen);
    logic [63:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:     imm = {{52{instr[31]}}, instr[31:20]};
      FMT_S:     imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:     imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:     imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_SHAMT: imm = (xlen == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      FMT_CSR:   imm = {59'b0, instr[19:15]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

  function automatic imm_fmt_e decode_fmt(input logic [31:0] instr);
    imm_fmt_e fmt;
    fmt = FMT_RSV;
    case (instr[6:0])
      OP_IMM:              fmt = (instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
      OP_LOAD, OP_JALR:    fmt = FMT_I;
      OP_STORE:            fmt = FMT_S;
      OP_BRANCH:           fmt = FMT_B;
      OP_JAL:              fmt = FMT_J;
      OP_LUI, OP_AUIPC:    fmt = FMT_U;
      OP_SYSTEM:           fmt = instr[14] ? FMT_CSR : FMT_I;
      default:             fmt = FMT_RSV;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data word, loading whenever it is
// empty or its downstream consumer drains it in the same cycle.
module imm_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         prev_valid,
  input  logic [W-1:0] prev_data,
  output logic         ready,
  input  logic         next_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  assign ready = !valid || next_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (ready) valid <= prev_valid;
      // Data may pick up a flushed entry; the cleared valid bit masks it.
      if (ready && prev_valid) data <= prev_data;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator with valid/ready handshake, backpressure and flush.
// Define IMM_GEN_AUTO_DECODE_EN to derive the format from the opcode instead of imm_src.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             fmt_err
);

  localparam int DW = XLEN + TAG_W + 1;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("imm_gen_pipe: STAGES must be 1 or 2");
  end

  imm_fmt_e    fmt;
  logic [63:0] imm_full;
  logic        unused_hi;

`ifdef IMM_GEN_AUTO_DECODE_EN
  logic unused_src;
  assign fmt        = decode_fmt(instr);
  assign unused_src = ^imm_src;
`else
  logic unused_op;
  assign fmt       = imm_fmt_e'(imm_src);
  assign unused_op = ^instr[6:0];
`endif

  assign imm_full  = ext_imm(instr, fmt, XLEN);
  assign unused_hi = ^imm_full;

  // Index s is the input of stage s; index STAGES is the block output.
  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [DW-1:0]   dat [STAGES+1];

  assign vld[0]      = in_valid;
  assign dat[0]      = {fmt == FMT_RSV, in_tag, imm_full[XLEN-1:0]};
  assign rdy[STAGES] = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    imm_pipe_stage #(.W(DW)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .prev_valid (vld[s]),
      .prev_data  (dat[s]),
      .ready      (rdy[s]),
      .next_ready (rdy[s+1]),
      .valid      (vld[s+1]),
      .data       (dat[s+1])
    );
  end

  // A flush swallows whatever is offered, so the offer always looks accepted.
  assign in_ready                     = rdy[0] || flush;
  assign out_valid                    = vld[STAGES];
  assign {fmt_err, out_tag, imm_ext}  = dat[STAGES];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/STAGES=1 and an XLEN=64/STAGES=2 instance share
// one input stream; a queue-based model checks every cycle, plus directed literal cases.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;
  logic [1:0]  ov, ir, orr, ferr;
  logic [4:0]  otag0, otag1;
  logic [31:0] imm32;
  logic [63:0] imm64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
    int          pc;
  } ent_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(ov[0]),
    .out_ready(orr[0]), .imm_ext(imm32), .out_tag(otag0), .fmt_err(ferr[0])
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(ov[1]),
    .out_ready(orr[1]), .imm_ext(imm64), .out_tag(otag1), .fmt_err(ferr[1])
  );

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk(act === exp, nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {err, imm} straight from the format table, using signed field values.
  function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] f, input int xl);
    longint v;
    logic   e;
    e = 1'b0;
    case (f)
      3'd0: v = longint'($signed(i[31:20]));
      3'd1: v = longint'($signed({i[31:25], i[11:7]}));
      3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd4: v = longint'($signed({i[31:12], 12'b0}));
      3'd5: v = (xl == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
      3'd6: v = longint'(i[19:15]);
      default: begin v = 0; e = 1'b1; end
    endcase
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {e, v};
  endfunction

  function automatic logic [2:0] ref_decode(input logic [31:0] i);
    case (i[6:0])
      7'b0010011: return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd5 : 3'd0;
      7'b0000011, 7'b1100111: return 3'd0;
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1110011: return i[14] ? 3'd6 : 3'd0;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] ref_fmt(input logic [31:0] i, input logic [2:0] src);
`ifdef IMM_GEN_AUTO_DECODE_EN
    return ref_decode(i);
`else
    return src;
`endif
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_chk
    localparam int ST = (k == 0) ? 1 : 2;
    localparam int XL = (k == 0) ? 32 : 64;
    ent_t q[$];
    logic [63:0] imm_k;
    logic [4:0]  tag_k;
    assign imm_k = (k == 0) ? {32'b0, imm32} : imm64;
    assign tag_k = (k == 0) ? otag0 : otag1;

    always @(negedge clk) begin : cmp
      ent_t        e;
      logic        eov, eir;
      logic [64:0] r;
      if (!rst_n) begin
        q.delete();
        eq($sformatf("rst_ov%0d", k), ov[k], 1'b0);
        eq($sformatf("rst_imm%0d", k), imm_k, 64'd0);
        eq($sformatf("rst_tag%0d", k), tag_k, 5'd0);
        eq($sformatf("rst_err%0d", k), ferr[k], 1'b0);
      end else begin
        // The oldest entry is visible once it has spent ST-1 edges past its capture.
        eov = (q.size() > 0) && ((cyc - q[0].pc) >= ST - 1);
        eq($sformatf("out_valid%0d", k), ov[k], eov);
        if (eov) begin
          eq($sformatf("imm%0d", k), imm_k, q[0].imm);
          eq($sformatf("tag%0d", k), tag_k, q[0].tag);
          eq($sformatf("err%0d", k), ferr[k], q[0].err);
        end
        eir = flush || (q.size() < ST) || (eov && orr[k]);
        eq($sformatf("in_ready%0d", k), ir[k], eir);
        if (flush) begin
          q.delete();
        end else begin
          if (ov[k] && orr[k] && q.size() > 0) void'(q.pop_front());
          if (in_valid && ir[k]) begin
            r     = ref_imm(instr, ref_fmt(instr, imm_src), XL);
            e.imm = r[63:0];
            e.err = r[64];
            e.tag = in_tag;
            e.pc  = cyc + 1;
            q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] held;
    int t;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0; in_tag = '0;
    orr = 2'b11;
    step(); step();
    eq("reset_ov", {62'b0, ov}, 64'd0);
    rst_n = 1'b1;

    eq("model_i32", ref_imm(32'hFFF00093, 3'd0, 32), {1'b0, 64'hFFFF_FFFF});
    eq("model_u64", ref_imm(32'h800002B7, 3'd4, 64), {1'b0, 64'hFFFF_FFFF_8000_0000});
    eq("model_sh64", ref_imm(32'h03F00013, 3'd5, 64), {1'b0, 64'h3F});
    eq("model_sh32", ref_imm(32'h03F00013, 3'd5, 32), {1'b0, 64'h1F});
    eq("model_rsv", ref_imm(32'hDEADBEEF, 3'd7, 64), {1'b1, 64'h0});
    eq("model_dec", {61'b0, ref_decode(32'h0002D073)}, 64'd6);
    step();

`ifndef IMM_GEN_AUTO_DECODE_EN
    in_valid = 1'b1; in_tag = 5'd1;
    imm_src = 3'd0; instr = 32'hFFF00093; step();
    eq("d_i32", imm32, 32'hFFFF_FFFF); eq("d_i32_v", ov[0], 1'b1);
    imm_src = 3'd1; instr = 32'hFE112E23; step();
    eq("d_s32", imm32, 32'hFFFF_FFFC);
    imm_src = 3'd4; instr = 32'h123452B7; step();
    eq("d_u32", imm32, 32'h1234_5000);
    imm_src = 3'd3; instr = 32'h001000EF; step();
    eq("d_j32", imm32, 32'h0000_0800);
    imm_src = 3'd4; instr = 32'h800002B7; step();
    imm_src = 3'd5; instr = 32'h03F00013; step();
    eq("d_u64", imm64, 64'hFFFF_FFFF_8000_0000); eq("d_u64_v", ov[1], 1'b1);
    imm_src = 3'd7; instr = 32'hDEADBEEF; step();
    eq("d_sh64", imm64, 64'h3F);
    in_valid = 1'b0; step();
    eq("d_rsv64", imm64, 64'd0); eq("d_rsv64_err", ferr[1], 1'b1);
    step(); step();
`else
    imm_src = 3'd7; in_valid = 1'b1; in_tag = 5'd2;
    instr = 32'h00209093; step();
    eq("a_slli", imm32, 32'h2); eq("a_slli_err", ferr[0], 1'b0);
    instr = 32'h0002D073; step();
    eq("a_csrrwi", imm32, 32'h5);
    instr = 32'h0000007F; step();
    eq("a_rsv", imm32, 32'h0); eq("a_rsv_err", ferr[0], 1'b1);
    in_valid = 1'b0; step(); step(); step();
`endif

    // Backpressure on the two-stage instance while streaming tags 1..5.
    orr = 2'b01; in_valid = 1'b1; t = 1; in_tag = 5'd1; instr = 32'hFFF00093; imm_src = 3'd0;
    held = '0;
    for (int c = 0; c < 30 && t <= 5; c++) begin
      logic acc;
      if (c == 4) orr[1] = 1'b1;
      if (c == 2) begin
        eq("bp_accepts", t, 3);
        eq("bp_in_ready", ir[1], 1'b0);
        held = imm64;
        eq("bp_head_tag", otag1, 5'd1);
      end
      if (c == 3) begin
        eq("bp_stable_imm", imm64, held);
        eq("bp_stable_tag", otag1, 5'd1);
        eq("bp_stable_v", ov[1], 1'b1);
      end
      acc = ir[1];
      step();
      if (acc) begin
        t++;
        in_tag = 5'(t);
        instr = $urandom;
        imm_src = 3'($urandom_range(0, 6));
      end
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Flush with both stages full and an input offered on the same edge.
    orr = 2'b00; in_valid = 1'b1; in_tag = 5'd8; step();
    in_tag = 5'd9; step();
    in_tag = 5'd30; flush = 1'b1; #1;
    eq("fl_in_ready", ir[1], 1'b1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    eq("fl_ov64", ov[1], 1'b0); eq("fl_ov32", ov[0], 1'b0);
    orr = 2'b11;
    repeat (3) step();

    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      instr    = $urandom;
      imm_src  = 3'($urandom);
      in_tag   = 5'($urandom);
      orr      = 2'($urandom);
      flush    = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream, then latency of the first new entry.
    in_valid = 1'b1; orr = 2'b00; instr = 32'hFE112E23; imm_src = 3'd1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    eq("ar_ov", {62'b0, ov}, 64'd0);
    eq("ar_imm32", imm32, 32'd0);
    eq("ar_imm64", imm64, 64'd0);
    step(); step();
    rst_n = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0; in_tag = 5'd3; orr = 2'b11;
    step();
    eq("ar_lat32_v", ov[0], 1'b1); eq("ar_lat32", imm32, 32'hFFFF_FFFF);
    eq("ar_lat64_v0", ov[1], 1'b0);
    in_valid = 1'b0;
    step();
    eq("ar_lat64_v", ov[1], 1'b1); eq("ar_lat64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RV32/RV64 datapath. It accepts full 32-bit instructions plus a 3-bit format select over a valid/ready handshake. It emits the sign- or zero-extended XLEN immediate after a configurable number of register stages. It sits between the decode stage and the execute operand mux and supports backpressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
STAGES, 1, register stages from acceptance to output; legal values 1 or 2.
TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. rd index).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all in-flight entries
in_valid  input  1  instruction presented
in_ready  output  1  block can accept this cycle
instr  input  32  raw instruction word
imm_src  input  3  format select (ignored when the optional feature is compiled in)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  immediate available
out_ready  input  1  consumer accepts this cycle
imm_ext  output  XLEN  extended immediate
out_tag  output  TAG_W  tag of the emitted entry
fmt_err  output  1  entry used a reserved format

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n=0, all stage valid bits, imm_ext, out_tag and fmt_err are 0, and out_valid=0.
- Format encoding (imm_src); bits in the X{...} fields are replicated to fill XLEN:
  - 000 I: sign-extend instr[31:20].
  - 001 S: sign-extend {instr[31:25], instr[11:7]}.
  - 010 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN=64.
  - 101 SHAMT: zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 110 CSR zimm: zero-extend instr[19:15].
  - 111 reserved: imm_ext=0, fmt_err=1.
- Computation: the immediate is computed combinationally on the input side and captured into stage 0. Stage 1 (STAGES=2) is a plain register copy.
- Elastic pipeline: each stage holds valid, imm, tag and err.
  - A stage loads when it is empty or when its downstream stage (or the output, for the last stage) is draining in the same cycle.
  - in_ready = !v[0] || stage 0 advances. The ready chain is combinational from out_ready.
  - Transfer happens on in_valid && in_ready; output handshake completes on out_valid && out_ready.
- Latency: with no backpressure, an entry accepted at edge N is visible on imm_ext/out_valid after edge N+STAGES-1, i.e. STAGES-1 cycles of register delay beyond the capture edge. Throughput is one entry per cycle.
- Backpressure: while out_valid=1 and out_ready=0, the outputs hold stable and unchanged. in_ready drops once every stage is full.
- Simultaneous fill and drain: when the last stage drains and the upstream stage advances in the same cycle, there is no bubble.
- Flush: on an edge where flush=1, all valid bits clear. Any input offered in that same cycle is dropped, and in_ready still reads 1. Data registers may retain stale values; out_valid=0 masks them.
- Reset mid-operation: entries are lost immediately. No output handshake completes during reset.
- Undefined behaviour: XLEN or STAGES outside the legal values is undefined; the block elaborates with a $error.

Optional Feature:
Macro IMM_GEN_AUTO_DECODE_EN.
- Defined: imm_src is ignored and the format is derived from instr[6:0]:
  - 0010011 with funct3 001/101 → SHAMT; 0000011, 1100111, other 0010011 → I.
  - 0100011 → S; 1100011 → B; 1101111 → J; 0110111, 0010111 → U.
  - 1110011 with funct3[2]=1 → CSR zimm; 1110011 otherwise → I.
  - Any other opcode → reserved (fmt_err=1, imm_ext=0).
- Undefined: imm_src drives the format directly. The port remains present in both builds.

Decomposition:
- Package imm_gen_pkg holds:
  - the imm_fmt_e enum (3-bit, values above);
  - opcode localparams;
  - a function ext_imm(instr, fmt, xlen) returning the XLEN immediate.
- One sub-module, imm_pipe_stage: a single valid/data register with load/advance logic, instantiated STAGES times.

Test Plan:
- XLEN=32, STAGES=1, out_ready=1. I: 0xFFF00093 → 0xFFFFFFFF. S: 0xFE112E23 → 0xFFFFFFFC. U: 0x123452B7 → 0x12345000. J: 0x001000EF → 0x00000800. All back-to-back, one result per cycle.
- XLEN=64, U 0x800002B7 → 0xFFFFFFFF80000000. SHAMT with instr[25:20]=0x3F → 0x000000000000003F. Reserved 111 → imm_ext=0, fmt_err=1.
- STAGES=2 backpressure:
  - Hold out_ready=0 for 4 cycles while streaming tags 1..5.
  - Required: in_ready falls after 2 accepts and the output stays stable.
  - On release, tags emerge 1,2,3… with no loss or duplication.
- Flush with both stages full and in_valid=1 on the same edge → out_valid=0 next cycle, and the offered entry never appears.
- Assert rst_n=0 asynchronously mid-stream → out_valid and imm_ext go to 0 without a clock. After release the first new input produces correct latency.
- IMM_GEN_AUTO_DECODE_EN defined, imm_src tied to 111. 0x00209093 (slli) → 0x2. 0x0002D073 (csrrwi zimm=5) → 0x5. Opcode 0x7F → fmt_err=1.
